or1k_spr_access: RTL and testbench

//  SPR access responder/forwarder for l.mfspr/l.mtspr issued by the execute stage.

---
 rtl/or1k_spr_access_if.sv | 12 +
 rtl/or1k_spr_access.sv | 135 +++++++++++++
 tb/tb_or1k_spr_access.sv | 239 +++++++++++++++++++++++
 3 files changed

// File: rtl/or1k_spr_access_if.sv
// External SPR bus: the SPR access unit is the master, group-specific SPR slaves respond.
interface or1k_spr_access_if #(parameter int DW = 32);
   logic          stb;
   logic          we;
   logic [15:0]   addr;
   logic [DW-1:0] wdat;
   logic          ack;
   logic [DW-1:0] rdat;

   modport master (output stb, we, addr, wdat, input ack, rdat);
   modport slave  (input stb, we, addr, wdat, output ack, rdat);
endinterface

// File: rtl/or1k_spr_access.sv
// l.mfspr/l.mtspr responder: group-0 config SPRs served locally, other groups forwarded
// to the external SPR bus with an optional stb-timeout watchdog.
module or1k_spr_access #(
   parameter int    OPTION_OPERAND_WIDTH = 32,
   parameter string FEATURE_SPR_TIMEOUT  = "ENABLED",
   parameter int    OPTION_SPR_TIMEOUT   = 255
) (
   input  logic                            cpu_clk,
   input  logic                            cpu_rst,
   input  logic                            req_i,
   input  logic                            we_i,
   input  logic [15:0]                     addr_i,
   input  logic [OPTION_OPERAND_WIDTH-1:0] wdat_i,
   input  logic                            flush_i,
   output logic                            busy_o,
   output logic                            ack_o,
   output logic [OPTION_OPERAND_WIDTH-1:0] rdat_o,
   output logic                            err_o,
   input  logic [OPTION_OPERAND_WIDTH-1:0] spr_vr,
   input  logic [OPTION_OPERAND_WIDTH-1:0] spr_upr,
   input  logic [OPTION_OPERAND_WIDTH-1:0] spr_cpucfgr,
   input  logic [OPTION_OPERAND_WIDTH-1:0] spr_dmmucfgr,
   input  logic [OPTION_OPERAND_WIDTH-1:0] spr_immucfgr,
   input  logic [OPTION_OPERAND_WIDTH-1:0] spr_dccfgr,
   input  logic [OPTION_OPERAND_WIDTH-1:0] spr_iccfgr,
   input  logic [OPTION_OPERAND_WIDTH-1:0] spr_dcfgr,
   input  logic [OPTION_OPERAND_WIDTH-1:0] spr_pccfgr,
   input  logic [OPTION_OPERAND_WIDTH-1:0] spr_vr2,
   input  logic [OPTION_OPERAND_WIDTH-1:0] spr_avr,
   or1k_spr_access_if.master               spr_bus
);

   localparam int          W           = OPTION_OPERAND_WIDTH;
   localparam bit          TIMEOUT_EN  = (FEATURE_SPR_TIMEOUT != "NONE");
   localparam logic [15:0] TIMEOUT_LIM = 16'(OPTION_SPR_TIMEOUT);

   typedef enum logic [1:0] {IDLE, LOCAL, EXT, RESP} state_t;

   state_t         state, state_nxt;
   logic           we_q;
   logic [15:0]    addr_q;
   logic [W-1:0]   wdat_q;
   logic [W-1:0]   rdat_q;
   logic           err_q;
   logic [15:0]    tmo_cnt;
   logic [W-1:0]   cfg_rdat;
   logic           accept;
   logic           is_local;
   logic           tmo_hit;

   assign accept   = (state == IDLE) & req_i & ~flush_i;
   assign is_local = (addr_i[15:11] == 5'd0);
   // tmo_cnt holds the number of completed EXT cycles, so the limit is hit on the last allowed one
   assign tmo_hit  = TIMEOUT_EN && ((tmo_cnt + 16'd1) == TIMEOUT_LIM);

   always_comb begin
      cfg_rdat = '0;
      case (addr_i[10:0])
         11'd0:   cfg_rdat = spr_vr;
         11'd1:   cfg_rdat = spr_upr;
         11'd2:   cfg_rdat = spr_cpucfgr;
         11'd3:   cfg_rdat = spr_dmmucfgr;
         11'd4:   cfg_rdat = spr_immucfgr;
         11'd5:   cfg_rdat = spr_dccfgr;
         11'd6:   cfg_rdat = spr_iccfgr;
         11'd7:   cfg_rdat = spr_dcfgr;
         11'd8:   cfg_rdat = spr_pccfgr;
         11'd9:   cfg_rdat = spr_vr2;
         11'd10:  cfg_rdat = spr_avr;
         default: cfg_rdat = '0;
      endcase
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (accept) state_nxt = is_local ? LOCAL : EXT;
         LOCAL:   state_nxt = IDLE;
         EXT: begin
            if (flush_i)                    state_nxt = IDLE;
            else if (spr_bus.ack || tmo_hit) state_nxt = RESP;
         end
         RESP:    state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge cpu_clk) begin
      if (cpu_rst) state <= IDLE;
      else         state <= state_nxt;
   end

   always_ff @(posedge cpu_clk) begin
      if (cpu_rst) begin
         we_q    <= 1'b0;
         addr_q  <= '0;
         wdat_q  <= '0;
         rdat_q  <= '0;
         err_q   <= 1'b0;
         tmo_cnt <= '0;
      end else begin
         if (accept) begin
            we_q   <= we_i;
            addr_q <= addr_i;
            wdat_q <= wdat_i;
         end
         tmo_cnt <= (state == EXT) ? tmo_cnt + 16'd1 : 16'd0;
         // rdat_q/err_q only carry the value presented in the following LOCAL/RESP cycle
         rdat_q <= '0;
         err_q  <= 1'b0;
         case (state)
            IDLE: if (accept && is_local && !we_i) rdat_q <= cfg_rdat;
            EXT: begin
               if (!flush_i) begin
                  if (spr_bus.ack)  rdat_q <= we_q ? '0 : spr_bus.rdat;
                  else if (tmo_hit) err_q  <= 1'b1;
               end
            end
            default: ;
         endcase
      end
   end

   // A flush in the response cycle must still kill the ack, hence the gating on flush_i
   assign ack_o  = ((state == LOCAL) || (state == RESP)) & ~flush_i;
   assign rdat_o = ack_o ? rdat_q : '0;
   assign err_o  = ack_o & err_q;
   assign busy_o = (state != IDLE);

   assign spr_bus.stb  = (state == EXT);
   assign spr_bus.we   = we_q;
   assign spr_bus.addr = addr_q;
   assign spr_bus.wdat = wdat_q;

endmodule

// File: tb/tb_or1k_spr_access.sv
// Self-checking bench for or1k_spr_access: table of local accesses, hand-written external
// sequences and randomized transactions against a transaction-level reference model.
module tb_or1k_spr_access;
   localparam int T = 4;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        req = 1'b0, we = 1'b0, flush = 1'b0;
   logic [15:0] addr = '0;
   logic [31:0] wdat = '0;
   logic        busy, ack, err;
   logic [31:0] rdat;
   logic [31:0] cfg [0:10];

   always #5 clk = ~clk;

   or1k_spr_access_if #(.DW(32)) bus ();

   or1k_spr_access #(
      .OPTION_OPERAND_WIDTH(32),
      .FEATURE_SPR_TIMEOUT ("ENABLED"),
      .OPTION_SPR_TIMEOUT  (T)
   ) dut (
      .cpu_clk(clk), .cpu_rst(rst),
      .req_i(req), .we_i(we), .addr_i(addr), .wdat_i(wdat), .flush_i(flush),
      .busy_o(busy), .ack_o(ack), .rdat_o(rdat), .err_o(err),
      .spr_vr(cfg[0]), .spr_upr(cfg[1]), .spr_cpucfgr(cfg[2]), .spr_dmmucfgr(cfg[3]),
      .spr_immucfgr(cfg[4]), .spr_dccfgr(cfg[5]), .spr_iccfgr(cfg[6]), .spr_dcfgr(cfg[7]),
      .spr_pccfgr(cfg[8]), .spr_vr2(cfg[9]), .spr_avr(cfg[10]),
      .spr_bus(bus.master)
   );

   int          n_tests = 0;
   int          n_fail  = 0;
   int          slv_delay = 1000;
   logic [31:0] slv_data  = '0;
   bit          late_ack  = 1'b0;
   int          scnt      = 0;

   // Slave: acks on the slv_delay-th stb cycle of an access, drives junk data otherwise
   always @(posedge clk) begin
      #2;
      if (bus.stb === 1'b1) scnt = scnt + 1;
      else                  scnt = 0;
      bus.ack  = late_ack || (bus.stb === 1'b1 && scnt == slv_delay);
      bus.rdat = bus.ack ? slv_data : $urandom;
   end

   always @(negedge clk)
      if (!rst) assert (!(req && busy)) else $error("request issued while busy");

   typedef struct {
      int          acks;
      int          ack_cyc;
      int          stb_n;
      logic [31:0] rd;
      logic        er;
      bit          busbad;
      bit          leak;
      logic        busy_end;
   } obs_t;

   typedef struct {
      logic        we;
      logic [15:0] addr;
      logic [31:0] wdat;
      logic [31:0] exp_rd;
   } vec_t;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
      end
   endtask

   // Issue one request in cycle 0, flush in cycle f (0 = never), observe cycles 1..T+4
   task automatic run_txn(input logic t_we, input logic [15:0] t_addr, input logic [31:0] t_wdat,
                          input int d, input int f, input logic [31:0] sdata, output obs_t o);
      o = '{acks: 0, ack_cyc: -1, stb_n: 0, rd: '0, er: 1'b0, busbad: 1'b0, leak: 1'b0, busy_end: 1'b0};
      slv_delay = d;
      slv_data  = sdata;
      @(posedge clk); #1;
      req = 1'b1; we = t_we; addr = t_addr; wdat = t_wdat; flush = 1'b0;
      for (int c = 1; c <= T + 4; c++) begin
         @(posedge clk); #1;
         req   = 1'b0;
         flush = (c == f);
         @(negedge clk);
         if (bus.stb) begin
            o.stb_n++;
            if (bus.addr !== t_addr || bus.we !== t_we || bus.wdat !== t_wdat) o.busbad = 1'b1;
         end
         if (ack) begin
            o.acks++;
            o.ack_cyc = c;
            o.rd = rdat;
            o.er = err;
         end else if (rdat !== '0 || err !== 1'b0) o.leak = 1'b1;
      end
      flush = 1'b0;
      o.busy_end = busy;
   endtask

   // Reference: local access takes one busy cycle; external takes min(d,T) stb cycles plus
   // one response cycle; a flush anywhere in the busy window kills the ack.
   task automatic chk_model(input string tag, input logic t_we, input logic [15:0] t_addr,
                            input int d, input int f, input logic [31:0] sdata, input obs_t o);
      bit          is_local;
      int          s, win, idx;
      bit          killed;
      logic [31:0] exp_rd;
      is_local = (t_addr[15:11] == 5'd0);
      s        = is_local ? 0 : ((d < T) ? d : T);
      win      = is_local ? 1 : s + 1;
      killed   = (f >= 1 && f <= win);
      idx      = int'(t_addr[10:0]);
      exp_rd   = '0;
      if (!t_we) begin
         if (is_local) exp_rd = (idx <= 10) ? cfg[idx] : 32'h0;
         else if (d <= T) exp_rd = sdata;
      end
      chk({tag, " ack count"}, o.acks, killed ? 0 : 1);
      if (!killed) begin
         chk({tag, " ack cycle"}, o.ack_cyc, win);
         chk({tag, " rdat"}, o.rd, exp_rd);
         chk({tag, " err"}, {31'd0, o.er}, {31'd0, !is_local && d > T});
      end
      chk({tag, " stb cycles"}, o.stb_n, killed ? ((f < s) ? f : s) : s);
      chk({tag, " bus fields"}, {31'd0, o.busbad}, 32'd0);
      chk({tag, " idle outputs zero"}, {31'd0, o.leak}, 32'd0);
      chk({tag, " busy at end"}, {31'd0, o.busy_end}, 32'd0);
   endtask

   vec_t vt [8];
   obs_t o;

   initial begin
      cfg[0] = 32'h1200_0001; cfg[1] = 32'h0000_0619; cfg[2]  = 32'h0000_0020;
      cfg[3] = 32'h0000_0A1B; cfg[4] = 32'h0000_0B2C; cfg[5]  = 32'h0000_0C3D;
      cfg[6] = 32'h0000_0D4E; cfg[7] = 32'h0000_0E5F; cfg[8]  = 32'h0000_0F60;
      cfg[9] = 32'h1234_0000; cfg[10] = 32'h0101_0000;

      vt[0] = '{1'b0, 16'h0001, 32'h0,         32'h0000_0619};
      vt[1] = '{1'b0, 16'h000A, 32'h0,         32'h0101_0000};
      vt[2] = '{1'b0, 16'h000F, 32'h0,         32'h0000_0000};
      vt[3] = '{1'b1, 16'h0002, 32'hFFFF_FFFF, 32'h0000_0000};
      vt[4] = '{1'b0, 16'h0000, 32'h0,         32'h1200_0001};
      vt[5] = '{1'b0, 16'h0008, 32'h0,         32'h0000_0F60};
      vt[6] = '{1'b0, 16'h07FF, 32'h0,         32'h0000_0000};
      vt[7] = '{1'b0, 16'h0009, 32'h0,         32'h1234_0000};

      repeat (3) @(posedge clk);
      #1 rst = 1'b0;
      @(negedge clk);
      chk("reset busy", {31'd0, busy}, 32'd0);
      chk("reset ack", {31'd0, ack}, 32'd0);
      chk("reset rdat", rdat, 32'd0);
      chk("reset err", {31'd0, err}, 32'd0);
      chk("reset stb", {31'd0, bus.stb}, 32'd0);
      chk("reset bus addr", {16'd0, bus.addr}, 32'd0);

      for (int i = 0; i < 8; i++) begin
         run_txn(vt[i].we, vt[i].addr, vt[i].wdat, 1000, 0, 32'h0, o);
         chk($sformatf("local[%0d] acks", i), o.acks, 1);
         chk($sformatf("local[%0d] ack cycle", i), o.ack_cyc, 1);
         chk($sformatf("local[%0d] rdat", i), o.rd, vt[i].exp_rd);
         chk($sformatf("local[%0d] stb", i), o.stb_n, 0);
         chk($sformatf("local[%0d] err", i), {31'd0, o.er}, 32'd0);
      end

      run_txn(1'b0, 16'h2800, 32'h0, 3, 0, 32'hDEAD_BEEF, o);
      chk("ext read stb cycles", o.stb_n, 3);
      chk("ext read ack cycle", o.ack_cyc, 4);
      chk("ext read rdat", o.rd, 32'hDEAD_BEEF);
      chk("ext read err", {31'd0, o.er}, 32'd0);
      chk("ext read bus fields", {31'd0, o.busbad}, 32'd0);

      run_txn(1'b0, 16'h4004, 32'h0, 1000, 0, 32'h0000_CAFE, o);
      chk("timeout stb cycles", o.stb_n, T);
      chk("timeout ack cycle", o.ack_cyc, T + 1);
      chk("timeout err", {31'd0, o.er}, 32'd1);
      chk("timeout rdat", o.rd, 32'd0);
      @(posedge clk); #1 late_ack = 1'b1;
      @(negedge clk);
      chk("late ack ignored ack", {31'd0, ack}, 32'd0);
      chk("late ack ignored busy", {31'd0, busy}, 32'd0);
      @(posedge clk); #1 late_ack = 1'b0;
      @(negedge clk);
      chk("late ack after ack", {31'd0, ack}, 32'd0);

      run_txn(1'b0, 16'h3010, 32'h0, T, 0, 32'h5555_AAAA, o);
      chk("ack at limit stb cycles", o.stb_n, T);
      chk("ack at limit err", {31'd0, o.er}, 32'd0);
      chk("ack at limit rdat", o.rd, 32'h5555_AAAA);

      run_txn(1'b1, 16'h5000, 32'h1234_5678, 1000, 2, 32'h0, o);
      chk("flush acks", o.acks, 0);
      chk("flush stb cycles", o.stb_n, 2);
      chk("flush bus fields", {31'd0, o.busbad}, 32'd0);
      run_txn(1'b1, 16'h5000, 32'h1234_5678, 2, 0, 32'hFFFF_0000, o);
      chk("after flush ack cycle", o.ack_cyc, 3);
      chk("after flush write rdat", o.rd, 32'd0);

      slv_delay = 1000;
      @(posedge clk); #1;
      req = 1'b1; we = 1'b0; addr = 16'h6000; wdat = '0;
      @(posedge clk); #1 req = 1'b0;
      @(negedge clk);
      chk("pre reset stb", {31'd0, bus.stb}, 32'd1);
      @(posedge clk); #1 rst = 1'b1;
      @(posedge clk); #1 rst = 1'b0;
      @(negedge clk);
      chk("mid reset stb", {31'd0, bus.stb}, 32'd0);
      chk("mid reset busy", {31'd0, busy}, 32'd0);
      chk("mid reset ack", {31'd0, ack}, 32'd0);
      repeat (2) @(posedge clk);

      for (int i = 0; i < 60; i++) begin
         logic        r_we;
         logic [15:0] r_addr;
         logic [31:0] r_wdat, r_sd;
         int          r_d, r_f;
         r_we   = 1'($urandom_range(0, 1));
         if ($urandom_range(0, 1) == 1) r_addr = {12'd0, 4'($urandom_range(0, 15))};
         else                           r_addr = {5'($urandom_range(1, 31)), 11'($urandom)};
         r_wdat = $urandom;
         r_sd   = $urandom;
         r_d    = $urandom_range(1, 6);
         r_f    = ($urandom_range(0, 9) < 7) ? 0 : $urandom_range(1, 7);
         run_txn(r_we, r_addr, r_wdat, r_d, r_f, r_sd, o);
         chk_model($sformatf("rand[%0d]", i), r_we, r_addr, r_d, r_f, r_sd, o);
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
